// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one synchronous single-port VRAM between the display fetch path and
// the host (MCU) bus. Display reads normally win so scanout never underruns.
// A saturating starvation counter guarantees that a host request that keeps
// losing is eventually forced through. At most one memory operation is issued
// per cycle. Read data comes back two cycles after the ack, and a small tag
// pipeline tells which requester owns it.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   disp_req/disp_addr    display read request and address
//   disp_ack              display request accepted this cycle (combinational)
//   disp_rvalid/rdata     display read return
//   host_req/wr/addr/wdata host request (wr=1 write, wr=0 read)
//   host_ack              host request accepted this cycle (combinational)
//   host_rvalid/rdata     host read return
//   mem_en/wr/addr/wdata  registered VRAM command
//   mem_rdata             VRAM read data, valid one cycle after a read strobe
module vram_arbiter #(
   parameter int ADDR_WIDTH    = 15,
   parameter int DATA_WIDTH    = 16,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  disp_req,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic                  disp_ack,
   output logic                  disp_rvalid,
   output logic [DATA_WIDTH-1:0] disp_rdata,
   input  logic                  host_req,
   input  logic                  host_wr,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic                  host_rvalid,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

   typedef enum logic {
      OWNER_DISP = 1'b0,
      OWNER_HOST = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   rd;
   } tag_t;

   logic [WAIT_W-1:0] host_wait;
   logic              host_forced;
   logic              disp_win;
   logic              host_win;
   tag_t              tag_s1;
   tag_t              tag_s2;

   // Arbitration. The host only beats a simultaneous display request once it
   // has lost HOST_MAX_WAIT times in a row. Both grants are suppressed while
   // reset is asserted so nothing is accepted that the reset would then drop.
   always_comb begin
      host_forced = (host_wait >= WAIT_MAX);
      host_win    = 1'b0;
      disp_win    = 1'b0;
      if (!reset) begin
         host_win = host_req && (!disp_req || host_forced);
         disp_win = disp_req && !(host_req && host_forced);
      end
   end

   assign disp_ack = disp_win;
   assign host_ack = host_win;

   // Starvation counter: counts consecutive host losses and saturates. Any
   // cycle where the host is accepted or not requesting restarts it, so a
   // withdrawn request earns no credit toward a forced win.
   always_ff @(posedge clk) begin
      if (reset) begin
         host_wait <= '0;
      end else if (!host_req || host_win) begin
         host_wait <= '0;
      end else if (host_wait < WAIT_MAX) begin
         host_wait <= host_wait + 1'b1;
      end
   end

   // Command register toward the VRAM. The winner's command is captured at the
   // end of the grant cycle. With no winner only the strobe drops; the address
   // and data hold so the memory bus does not toggle needlessly.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= host_win || disp_win;
         if (host_win) begin
            mem_wr    <= host_wr;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
         end else if (disp_win) begin
            mem_wr   <= 1'b0;
            mem_addr <= disp_addr;
         end
      end
   end

   // Two-stage tag pipeline following each issued operation. Stage 2 lines up
   // with the cycle in which the VRAM presents read data. Clearing both stages
   // on reset guarantees that reads in flight never raise an rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_s1 <= '0;
         tag_s2 <= '0;
      end else begin
         tag_s1.valid <= host_win || disp_win;
         tag_s1.owner <= host_win ? OWNER_HOST : OWNER_DISP;
         tag_s1.rd    <= host_win ? !host_wr : 1'b1;
         tag_s2       <= tag_s1;
      end
   end

   // Read returns: the data bus is shared and only the owner's valid rises.
   // Write tags carry rd=0 and therefore produce no rvalid.
   always_comb begin
      disp_rvalid = tag_s2.valid && tag_s2.rd && (tag_s2.owner == OWNER_DISP);
      host_rvalid = tag_s2.valid && tag_s2.rd && (tag_s2.owner == OWNER_HOST);
      disp_rdata  = mem_rdata;
      host_rdata  = mem_rdata;
   end

endmodule
